// File: rtl/sata_fifo_drain_pkg.sv
// sata_fifo_drain_pkg: shared SATA state encodings and default frame-length width
package sata_fifo_drain_pkg;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam int LGLEN = 12;
endpackage

// File: rtl/sata_fifo_drain.sv
// sata_fifo_drain: pops a commanded number of FIFO words into a registered valid/ready stream
module sata_fifo_drain #(
    parameter int BW    = 32,
    parameter int LGLEN = sata_fifo_drain_pkg::LGLEN
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [LGLEN:0]   i_len,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             o_fifo_rd,
    input  logic [BW-1:0]    i_fifo_data,
    input  logic             i_fifo_empty,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [BW-1:0]    o_data,
    output logic             o_last,
    output logic             o_done,
    output logic             o_err,
    output logic [LGLEN:0]   o_sent
);
    import sata_fifo_drain_pkg::*;

    localparam logic [LGLEN:0] ONE = (LGLEN+1)'(1);

    logic [1:0]     state_q, state_d;
    logic [LGLEN:0] rem_q, rem_d, sent_q, sent_d;
    logic [BW-1:0]  data_q, data_d;
    logic           valid_q, valid_d, last_q, last_d, done_q, done_d, err_q, err_d;
    logic           start, abort, accept, pop, fin;

    assign start  = state_q == IDLE && i_start && i_len != '0;
    assign abort  = state_q != IDLE && i_abort;
    assign accept = valid_q && i_ready;
    assign pop    = state_q == RUN && rem_q != '0 && !i_fifo_empty && (!valid_q || i_ready) && !i_abort;
    // abort takes priority over a simultaneous final acceptance
    assign fin    = state_q == DRAIN && accept && last_q && !i_abort;

    always_comb begin
        state_d = abort ? IDLE : start ? RUN : (pop && rem_q == ONE) ? DRAIN : fin ? IDLE : state_q;
        rem_d   = start ? i_len : abort ? '0 : pop ? rem_q - ONE : rem_q;
        sent_d  = start ? '0 : (accept && !abort) ? sent_q + ONE : sent_q;
        valid_d = abort ? 1'b0 : pop ? 1'b1 : accept ? 1'b0 : valid_q;
        last_d  = abort ? 1'b0 : pop ? rem_q == ONE : accept ? 1'b0 : last_q;
        data_d  = pop ? i_fifo_data : data_q;
        done_d  = abort || fin;
        err_d   = abort;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            sent_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            sent_q  <= sent_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign o_busy    = state_q != IDLE;
    assign o_fifo_rd = pop;
    assign o_valid   = valid_q;
    assign o_data    = data_q;
    assign o_last    = last_q;
    assign o_done    = done_q;
    assign o_err     = err_q;
    assign o_sent    = sent_q;
endmodule
